stream_avg: RTL and testbench
=============================

STREAM_AVG -- requirements
Module: stream_avg

Interface
REQ-001 Parameter WIDTH, default 5, sample and average width in bits.
REQ-002 Parameter LOG2N, default 2, log2 of window length N (N = 2^LOG2N, LOG2N >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_vld  input  1  sample strobe; high = in_data valid this cycle; no backpressure.
REQ-006 in_data  input  WIDTH  sample value, unsigned; driven by upstream up/down counter count.
REQ-007 in_ovflw  input  1  upstream counter overflow flag, qualified by in_vld.
REQ-008 clr  input  1  synchronous window abort; discards partial accumulation.
REQ-009 out_vld  output  1  average result valid, held until accepted.
REQ-010 out_rdy  input  1  consumer accept; transfer when out_vld && out_rdy.
REQ-011 out_avg  output  WIDTH  window average.
REQ-012 out_ovf  output  1  one or more samples in the reported window had in_ovflw=1.
REQ-013 out_lost  output  1  sticky; an unaccepted result was overwritten.
REQ-014 busy  output  1  high while state is ACC.

Function
REQ-015 Accumulator SHALL be WIDTH+LOG2N bits unsigned; no internal overflow possible.
REQ-016 Window sample counter SHALL be LOG2N bits, wrapping from N-1 to 0.
REQ-017 FSM SHALL have states IDLE and ACC only.
REQ-018 IDLE, in_vld=1: acc <= in_data, cnt <= 1, window ovf <= in_ovflw, go ACC.
REQ-019 ACC, in_vld=1, cnt < N-1: acc <= acc+in_data, cnt++, window ovf |= in_ovflw.
REQ-020 ACC, in_vld=1, cnt = N-1: N-th sample; result formed from acc+in_data, go IDLE.
REQ-021 in_vld=0: acc, cnt and state SHALL hold; gaps between samples are unbounded.
REQ-022 Result SHALL appear on out_avg/out_ovf with out_vld=1 one cycle after the N-th sample edge (latency 1).
REQ-023 out_avg, out_ovf, out_vld SHALL hold stable while out_vld && !out_rdy.
REQ-024 out_vld SHALL clear the cycle after out_vld && out_rdy, unless a new result loads that same edge.
REQ-025 New result while out_vld=1 and out_rdy=0: overwrite output registers, keep out_vld=1, set out_lost.
REQ-026 New result in the same cycle as accept (out_rdy=1): load new result, out_vld stays 1, out_lost unchanged.
REQ-027 clr=1: state <= IDLE, acc/cnt/window ovf <= 0; same-cycle in_vld sample discarded; output registers and out_lost unaffected.
REQ-028 N=1 edge case excluded by REQ-002; LOG2N=1 SHALL average pairs.

Reset
REQ-029 rst_n=0 at rising edge: state IDLE, acc 0, cnt 0, out_vld 0, out_avg 0, out_ovf 0, out_lost 0, busy 0.
REQ-030 Reset SHALL take priority over clr, in_vld and out_rdy; mid-window reset discards the partial window.
REQ-031 out_lost SHALL clear only by reset.

Configuration
REQ-032 Macro AVG_ROUND_EN defined: out_avg = (sum + 2^(LOG2N-1)) >> LOG2N (round half up; fits WIDTH bits, no saturation needed).
REQ-033 AVG_ROUND_EN undefined: out_avg = sum >> LOG2N (truncate).

Verification (WIDTH=5, LOG2N=2)
REQ-034 rst_n=0 10 cycles, then in_vld pulses 1,2,3,4 -> out_vld 1 cycle after 4th; out_avg=2 (truncate) or 3 (AVG_ROUND_EN); out_ovf=0.
REQ-035 Four samples of 31, 3rd with in_ovflw=1 -> out_avg=31, out_ovf=1, out_lost=0.
REQ-036 out_rdy=0, two full windows (1,1,1,1 then 5,5,5,5) -> out_avg=5 after second, out_lost=1, out_vld held; out_rdy=1 -> out_vld falls next cycle.
REQ-037 Samples 7,7 then clr with in_vld=1 (data 9), then 2,2,2,2 -> busy falls on clr, single result out_avg=2.
REQ-038 Samples 3,3,3, then rst_n=0 one cycle, then 4,4,4,4 -> one result out_avg=4, out_lost=0.
REQ-039 Sparse in_vld (random 0-5 idle cycles) over 8 samples 0..7 -> results 1 then 5 (truncate) or 2 then 6 (AVG_ROUND_EN).

Source files
------------

// File: rtl/stream_avg.sv
// rtl/stream_avg.sv - N-sample window averager with held result register; define AVG_ROUND_EN for round-half-up output
module stream_avg #(
    parameter int WIDTH = 5,
    parameter int LOG2N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ovflw,
    input  logic             clr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_avg,
    output logic             out_ovf,
    output logic             out_lost,
    output logic             busy
);

    localparam int AW = WIDTH + LOG2N;

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    acc;
    logic [LOG2N-1:0] cnt;
    logic             win_ovf;
    logic             last;
    logic             done;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    rsum;

    assign sum  = acc + {{LOG2N{1'b0}}, in_data};
    assign last = (cnt == {LOG2N{1'b1}});

`ifdef AVG_ROUND_EN
    localparam logic [AW-1:0] HALF = AW'(1) << (LOG2N - 1);
    // Max sum plus half an LSB still stays below N*2^WIDTH, so no carry out
    assign rsum = sum + HALF;
`else
    assign rsum = sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (in_vld) begin
            case (state)
                IDLE:    state_nxt = ACC;
                ACC:     state_nxt = last ? IDLE : ACC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == ACC);
        done = (state == ACC) && in_vld && last && !clr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            win_ovf  <= 1'b0;
            out_vld  <= 1'b0;
            out_avg  <= '0;
            out_ovf  <= 1'b0;
            out_lost <= 1'b0;
        end else begin
            if (clr) begin
                acc     <= '0;
                cnt     <= '0;
                win_ovf <= 1'b0;
            end else if (in_vld) begin
                if (state == IDLE) begin
                    acc     <= {{LOG2N{1'b0}}, in_data};
                    cnt     <= LOG2N'(1);
                    win_ovf <= in_ovflw;
                end else if (last) begin
                    acc     <= '0;
                    cnt     <= '0;
                    win_ovf <= 1'b0;
                end else begin
                    acc     <= sum;
                    cnt     <= cnt + LOG2N'(1);
                    win_ovf <= win_ovf | in_ovflw;
                end
            end

            // A fresh result always wins the output register; an unaccepted one is reported lost
            if (done) begin
                out_avg <= rsum[AW-1:LOG2N];
                out_ovf <= win_ovf | in_ovflw;
                out_vld <= 1'b1;
                if (out_vld && !out_rdy) begin
                    out_lost <= 1'b1;
                end
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_avg.sv
// tb/tb_stream_avg.sv - directed self-checking bench for stream_avg (WIDTH=5, LOG2N=2)
module tb_stream_avg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic [4:0] in_data;
    logic       in_ovflw;
    logic       clr;
    logic       out_vld;
    logic       out_rdy;
    logic [4:0] out_avg;
    logic       out_ovf;
    logic       out_lost;
    logic       busy;

    int checks = 0;
    int errors = 0;

    stream_avg #(.WIDTH(5), .LOG2N(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_ovflw (in_ovflw),
        .clr      (clr),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_avg  (out_avg),
        .out_ovf  (out_ovf),
        .out_lost (out_lost),
        .busy     (busy)
    );

    always #5 clk = ~clk;

`ifdef AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input int d, input bit ovf);
        in_vld   = 1'b1;
        in_data  = 5'(d);
        in_ovflw = ovf;
        tick();
        in_vld   = 1'b0;
        in_ovflw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_ovflw = 1'b0;
        clr = 1'b0; out_rdy = 1'b1;
        repeat (10) tick();
        check("rst_out_vld", out_vld, 0);
        check("rst_out_avg", out_avg, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_lost", out_lost, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // 1,2,3,4: sum 10
        sample(1, 0);
        check("w1_busy", busy, 1);
        sample(2, 0);
        sample(3, 0);
        check("w1_no_early", out_vld, 0);
        sample(4, 0);
        check("w1_vld", out_vld, 1);
        check("w1_avg", out_avg, RND ? 3 : 2);
        check("w1_ovf", out_ovf, 0);
        check("w1_busy_end", busy, 0);
        tick();
        check("w1_accept", out_vld, 0);

        // 31 x4 with overflow on 3rd: sum 124
        sample(31, 0); sample(31, 0); sample(31, 1); sample(31, 0);
        check("w2_vld", out_vld, 1);
        check("w2_avg", out_avg, 31);
        check("w2_ovf", out_ovf, 1);
        check("w2_lost", out_lost, 0);
        tick();

        // overwrite without accept
        out_rdy = 1'b0;
        sample(1, 0); sample(1, 0); sample(1, 0); sample(1, 0);
        check("w3_vld", out_vld, 1);
        check("w3_avg", out_avg, 1);
        sample(5, 0);
        check("w3_hold_vld", out_vld, 1);
        check("w3_hold_avg", out_avg, 1);
        sample(5, 0); sample(5, 0); sample(5, 0);
        check("w4_avg", out_avg, 5);
        check("w4_lost", out_lost, 1);
        check("w4_vld", out_vld, 1);
        tick();
        check("w4_held_vld", out_vld, 1);
        check("w4_held_avg", out_avg, 5);
        out_rdy = 1'b1;
        tick();
        check("w4_accept", out_vld, 0);
        check("w4_lost_sticky", out_lost, 1);

        // clr mid-window with a same-cycle sample
        sample(7, 0); sample(7, 0);
        check("clr_busy_before", busy, 1);
        clr = 1'b1;
        sample(9, 0);
        clr = 1'b0;
        check("clr_busy_after", busy, 0);
        check("clr_lost_kept", out_lost, 1);
        check("clr_no_vld", out_vld, 0);
        sample(2, 0); sample(2, 0); sample(2, 0);
        check("clr_no_early", out_vld, 0);
        sample(2, 0);
        check("clr_vld", out_vld, 1);
        check("clr_avg", out_avg, 2);
        tick();
        check("clr_single", out_vld, 0);

        // mid-window reset
        sample(3, 0); sample(3, 0); sample(3, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", busy, 0);
        check("mrst_lost", out_lost, 0);
        out_rdy = 1'b0;
        sample(4, 0); sample(4, 0); sample(4, 0);
        check("mrst_no_early", out_vld, 0);
        sample(4, 0);
        check("mrst_vld", out_vld, 1);
        check("mrst_avg", out_avg, 4);
        check("mrst_lost_after", out_lost, 0);

        // accept coincides with new result: no loss
        sample(6, 0); sample(6, 0); sample(6, 0);
        out_rdy = 1'b1;
        sample(6, 0);
        check("acc_new_vld", out_vld, 1);
        check("acc_new_avg", out_avg, 6);
        check("acc_new_lost", out_lost, 0);
        tick();
        check("acc_new_clear", out_vld, 0);

        // sparse samples 0..7: sums 6 and 22
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            sample(i, 0);
            if (i == 3) begin
                check("sp1_vld", out_vld, 1);
                check("sp1_avg", out_avg, RND ? 2 : 1);
            end else if (i == 7) begin
                check("sp2_vld", out_vld, 1);
                check("sp2_avg", out_avg, RND ? 6 : 5);
            end
        end
        tick();
        check("sp_end", out_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
